// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction ROM program counter and run/halt sequencer
// Optional cycle counter output enabled by FETCH_CYCLE_CNT_EN.
module fetch_sequencer #(
    parameter int             A          = 10,
    parameter int             OFF_W      = 6,
    parameter logic [A-1:0]   START_ADDR = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             HaltReq,
    input  logic             BranchEn,
    input  logic             BranchRel,
    input  logic [A-1:0]     Target,
    input  logic [OFF_W-1:0] Offset,
    input  logic             Stall,
`ifdef FETCH_CYCLE_CNT_EN
    output logic [15:0]      CycleCount,
`endif
    output logic [A-1:0]     InstAddress,
    output logic             Running,
    output logic             Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   pc_q, pc_d;
    logic [A-1:0]   offset_ext;

    assign offset_ext = {{(A-OFF_W){Offset[OFF_W-1]}}, Offset};

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                end
            end
            ST_RUN: begin
                // Stall outranks halt and branch so a held instruction is re-evaluated later.
                if (Stall) begin
                    pc_d = pc_q;
                end else if (HaltReq) begin
                    state_d = ST_DONE;
                end else if (BranchEn) begin
                    pc_d = BranchRel ? pc_q + offset_ext : Target;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    assign InstAddress = pc_q;
    assign Running     = (state_q == ST_RUN);
    assign Done        = (state_q == ST_DONE);

`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] count_q, count_d;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (state_q != ST_RUN) begin
            if (Start) begin
                count_d = '0;
            end
        end else if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    assign CycleCount = count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        HaltReq = 1'b0;
    logic        BranchEn = 1'b0;
    logic        BranchRel = 1'b0;
    logic [9:0]  Target = '0;
    logic [5:0]  Offset = '0;
    logic        Stall = 1'b0;
    logic [9:0]  InstAddress;
    logic        Running;
    logic        Done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] CycleCount;
`endif

    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.A(10), .OFF_W(6), .START_ADDR(10'd0)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .HaltReq     (HaltReq),
        .BranchEn    (BranchEn),
        .BranchRel   (BranchRel),
        .Target      (Target),
        .Offset      (Offset),
        .Stall       (Stall),
`ifdef FETCH_CYCLE_CNT_EN
        .CycleCount  (CycleCount),
`endif
        .InstAddress (InstAddress),
        .Running     (Running),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    // Reference model: running/done flags, integer PC modulo 1024, counter.
    int exp_pc = 0;
    bit exp_run = 1'b0;
    bit exp_done = 1'b0;
    int exp_cnt = 0;
    bit model_valid = 1'b0;

    always @(posedge Clk) begin : model
        int npc, off, ncnt;
        bit nrun, ndone;
        npc = exp_pc; nrun = exp_run; ndone = exp_done; ncnt = exp_cnt;
        if (!Reset) begin
            npc = 0; nrun = 0; ndone = 0; ncnt = 0;
        end else if (!exp_run) begin
            if (Start) begin
                npc = 0; nrun = 1; ndone = 0; ncnt = 0;
            end
        end else begin
            ncnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
            if (Stall) begin
                npc = exp_pc;
            end else if (HaltReq) begin
                nrun = 0; ndone = 1;
            end else if (BranchEn) begin
                if (BranchRel) begin
                    off = int'(Offset);
                    if (off >= 32) off = off - 64;
                    npc = ((exp_pc + off) % 1024 + 1024) % 1024;
                end else begin
                    npc = int'(Target);
                end
            end else begin
                npc = (exp_pc + 1) % 1024;
            end
        end
        exp_pc <= npc; exp_run <= nrun; exp_done <= ndone; exp_cnt <= ncnt;
        model_valid <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (model_valid) begin
            chk("model_pc", int'(InstAddress), exp_pc);
            chk("model_running", int'(Running), int'(exp_run));
            chk("model_done", int'(Done), int'(exp_done));
`ifdef FETCH_CYCLE_CNT_EN
            chk("model_count", int'(CycleCount), exp_cnt);
`endif
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input int pc, input int run, input int dn);
        chk({name, "_pc"}, int'(InstAddress), pc);
        chk({name, "_running"}, int'(Running), run);
        chk({name, "_done"}, int'(Done), dn);
        chk({name, "_model_pc"}, exp_pc, pc);
    endtask

    initial begin
        // Reset held two cycles with Start asserted: Start must be ignored.
        Reset = 1'b0; Start = 1'b1;
        cyc(); cyc();
        expect_lit("reset", 0, 0, 0);
        Reset = 1'b1; Start = 1'b0;
        cyc();
        expect_lit("idle", 0, 0, 0);

        Start = 1'b1; cyc(); Start = 1'b0;
        expect_lit("start", 0, 1, 0);
        cyc(); expect_lit("seq1", 1, 1, 0);
        cyc(); expect_lit("seq2", 2, 1, 0);

        BranchEn = 1'b1; BranchRel = 1'b0; Target = 10'h03F;
        cyc(); expect_lit("abs_branch", 10'h03F, 1, 0);
        Target = 10'd5;
        cyc(); expect_lit("abs_to5", 5, 1, 0);
        BranchRel = 1'b1; Offset = 6'h3E;
        cyc(); expect_lit("rel_minus2", 3, 1, 0);
        BranchEn = 1'b0;
        repeat (4) cyc();
        expect_lit("seq7", 7, 1, 0);

        HaltReq = 1'b1; BranchEn = 1'b1; BranchRel = 1'b0; Target = 10'h100;
        cyc(); expect_lit("halt", 7, 0, 1);
        HaltReq = 1'b0; BranchEn = 1'b0;
        cyc(); expect_lit("done_hold", 7, 0, 1);
        Start = 1'b1; cyc(); Start = 1'b0;
        expect_lit("restart", 0, 1, 0);

        BranchEn = 1'b1; BranchRel = 1'b0; Target = 10'h3FF;
        cyc(); expect_lit("to_top", 10'h3FF, 1, 0);
        BranchRel = 1'b1; Offset = 6'h01;
        cyc(); expect_lit("wrap_up", 0, 1, 0);
        Offset = 6'h3F;
        cyc(); expect_lit("wrap_down", 10'h3FF, 1, 0);
        Offset = 6'h20;
        cyc(); expect_lit("rel_minus32", 10'h3DF, 1, 0);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_lit("stall", 10'h3DF, 1, 0);
        end
        Stall = 1'b0; BranchEn = 1'b0;
        cyc(); expect_lit("stall_resume", 10'h3E0, 1, 0);
        Stall = 1'b1; HaltReq = 1'b1;
        cyc(); expect_lit("stall_over_halt", 10'h3E0, 1, 0);
        Stall = 1'b0; HaltReq = 1'b0; Start = 1'b1;
        cyc(); expect_lit("start_in_run", 10'h3E1, 1, 0);
        Start = 1'b0;

        BranchEn = 1'b1; BranchRel = 1'b0; Target = 10'd9;
        cyc(); expect_lit("to9", 9, 1, 0);
        BranchEn = 1'b0; Reset = 1'b0;
        cyc(); expect_lit("mid_reset", 0, 0, 0);
        Reset = 1'b1;

        // Five RUN cycles: plain, two stalls, plain, then the halting cycle.
        Start = 1'b1; cyc(); Start = 1'b0;
        expect_lit("cnt_start", 0, 1, 0);
        cyc();
        Stall = 1'b1; cyc(); cyc(); Stall = 1'b0;
        cyc();
        HaltReq = 1'b1; cyc(); HaltReq = 1'b0;
        expect_lit("cnt_halt", 2, 0, 1);
`ifdef FETCH_CYCLE_CNT_EN
        chk("cycle_count", int'(CycleCount), 5);
`endif
        cyc(); expect_lit("cnt_hold", 2, 0, 1);
`ifdef FETCH_CYCLE_CNT_EN
        chk("cycle_count_hold", int'(CycleCount), 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
